// File: rtl/servo_pwm_decoder.sv
// rtl/servo_pwm_decoder.sv - servo pulse-width decoder back to a 2-bit direction code
module servo_pwm_decoder #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int PERIOD_US = 20000,
  parameter int REST_US   = 1500,
  parameter int LEFT_US   = 1000,
  parameter int RIGHT_US  = 2000,
  parameter int TOL_US    = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwm_in,
  output logic [1:0] direction,
  output logic       valid,
  output logic       pulse_error,
  output logic       signal_lost
);

  localparam int CYC_US  = CLK_FREQ / 1_000_000;
  localparam int W_REST  = REST_US * CYC_US;
  localparam int W_LEFT  = LEFT_US * CYC_US;
  localparam int W_RIGHT = RIGHT_US * CYC_US;
  localparam int W_TOL   = TOL_US * CYC_US;
  localparam int W_MAX   = (RIGHT_US + 4 * TOL_US) * CYC_US;
  localparam int T_LOST  = 2 * PERIOD_US * CYC_US;
  localparam int WW      = $clog2(W_MAX + 1);
  localparam int TW      = $clog2(T_LOST + 1);

  localparam logic [WW-1:0] W_MAX_C    = WW'(W_MAX);
  localparam logic [WW-1:0] REST_LO    = WW'(W_REST - W_TOL);
  localparam logic [WW-1:0] REST_HI    = WW'(W_REST + W_TOL);
  localparam logic [WW-1:0] LEFT_LO    = WW'(W_LEFT - W_TOL);
  localparam logic [WW-1:0] LEFT_HI    = WW'(W_LEFT + W_TOL);
  localparam logic [WW-1:0] RIGHT_LO   = WW'(W_RIGHT - W_TOL);
  localparam logic [WW-1:0] RIGHT_HI   = WW'(W_RIGHT + W_TOL);
  localparam logic [TW-1:0] T_LOST_C   = TW'(T_LOST);

  localparam logic [1:0] DIR_REST  = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  // Overlapping bands make the decode ambiguous; refuse to elaborate.
  if ((W_REST - W_TOL <= W_LEFT + W_TOL) || (W_RIGHT - W_TOL <= W_REST + W_TOL)) begin : g_band_overlap
    $error("servo_pwm_decoder: TOL_US makes the pulse bands overlap");
  end

  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    MEASURE   = 2'd1,
    DECODE    = 2'd2,
    STUCK     = 2'd3
  } state_t;

  state_t        state, state_d;
  logic          s1, s2, s3;
  logic          rise;
  logic          rise_pend, rise_pend_d;
  logic [WW-1:0] width, width_d;
  logic [TW-1:0] timeout, timeout_d;
  logic [1:0]    dir_d;
  logic          valid_d, err_d, lost_d;
  logic          in_rest, in_left, in_right;
  logic          match;
  logic [1:0]    code;

  assign rise = s2 & ~s3;

  // Two-flop synchroniser for the asynchronous pulse input plus one history flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Band classification of the measured high time; REST wins, then LEFT, then RIGHT.
  always_comb begin
    in_rest  = (width >= REST_LO)  && (width <= REST_HI);
    in_left  = (width >= LEFT_LO)  && (width <= LEFT_HI);
    in_right = (width >= RIGHT_LO) && (width <= RIGHT_HI);
    match    = in_rest | in_left | in_right;
    code     = DIR_REST;
    if (in_rest)       code = DIR_REST;
    else if (in_left)  code = DIR_LEFT;
    else if (in_right) code = DIR_RIGHT;
  end

  // State register, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= WAIT_RISE;
      width       <= '0;
      timeout     <= '0;
      rise_pend   <= 1'b0;
      direction   <= DIR_REST;
      valid       <= 1'b0;
      pulse_error <= 1'b0;
      signal_lost <= 1'b1;
    end else begin
      state       <= state_d;
      width       <= width_d;
      timeout     <= timeout_d;
      rise_pend   <= rise_pend_d;
      direction   <= dir_d;
      valid       <= valid_d;
      pulse_error <= err_d;
      signal_lost <= lost_d;
    end
  end

  // Next-state logic: measure high time, decode it, and watch for loss of the frame train.
  always_comb begin
    state_d     = state;
    width_d     = width;
    timeout_d   = (timeout == T_LOST_C) ? timeout : timeout + 1'b1;
    rise_pend_d = 1'b0;
    dir_d       = direction;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    lost_d      = signal_lost;

    case (state)
      WAIT_RISE: begin
        // A rise seen during DECODE was parked in rise_pend; the pulse is then one cycle older.
        if (rise || rise_pend) begin
          state_d   = MEASURE;
          width_d   = rise_pend ? (s2 ? WW'(2) : WW'(1)) : WW'(1);
          timeout_d = rise_pend ? TW'(1) : TW'(0);
        end
      end
      MEASURE: begin
        if (!s2) begin
          state_d = DECODE;
        end else begin
          if (width != W_MAX_C) width_d = width + 1'b1;
          if (width >= W_MAX_C - 1'b1) begin
            state_d = STUCK;
            err_d   = 1'b1;
          end
        end
      end
      DECODE: begin
        rise_pend_d = rise;
        state_d     = WAIT_RISE;
        if (match) begin
          dir_d   = code;
          valid_d = 1'b1;
          lost_d  = 1'b0;
        end else begin
          err_d = 1'b1;
        end
      end
      STUCK: begin
        if (!s2) state_d = WAIT_RISE;
      end
      default: state_d = WAIT_RISE;
    endcase

    // The rise-to-rise budget ran out: report loss and return the steering to rest.
    if ((timeout != T_LOST_C) && (timeout_d == T_LOST_C)) begin
      lost_d  = 1'b1;
      dir_d   = DIR_REST;
      valid_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// tb/tb_servo_pwm_decoder.sv - scoreboard bench for servo_pwm_decoder
module tb_servo_pwm_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       pwm_in;
  logic [1:0] direction;
  logic       valid;
  logic       pulse_error;
  logic       signal_lost;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int last_rise = 0;

  typedef struct {
    bit         err;
    logic [1:0] dir;
    int         at_cyc;
  } exp_t;

  exp_t q[$];

  servo_pwm_decoder #(
    .CLK_FREQ (1_000_000),
    .PERIOD_US(20000),
    .REST_US  (1500),
    .LEFT_US  (1000),
    .RIGHT_US (2000),
    .TOL_US   (100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pwm_in     (pwm_in),
    .direction  (direction),
    .valid      (valid),
    .pulse_error(pulse_error),
    .signal_lost(signal_lost)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: every valid or pulse_error strobe must match the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (!rst && (valid || pulse_error)) begin
      chk("strobe_exclusive", int'(valid && pulse_error), 0);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe valid=%0d pulse_error=%0d dir=%0d (cycle %0d)",
                 valid, pulse_error, direction, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("strobe_kind_is_error", int'(pulse_error), int'(e.err));
        chk("strobe_direction", int'(direction), int'(e.dir));
        if (e.at_cyc != 0) chk("strobe_latency_cycle", cyc, e.at_cyc);
      end
    end
  end

  // One high phase of hi cycles then lo cycles low; stuck pulses report before their fall.
  task automatic pulse(input int hi, input int lo, input bit err, input logic [1:0] dir,
                       input bit stuck);
    exp_t e;
    e.err = err;
    e.dir = dir;
    @(negedge clk);
    if (stuck) begin
      e.at_cyc = 0;
      q.push_back(e);
    end
    pwm_in = 1'b1;
    last_rise = cyc;
    repeat (hi) @(negedge clk);
    pwm_in = 1'b0;
    if (!stuck) begin
      e.at_cyc = cyc + 4;
      q.push_back(e);
    end
    repeat (lo) @(negedge clk);
  endtask

  initial begin
    rst    = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_direction", int'(direction), 0);
    chk("reset_valid", int'(valid), 0);
    chk("reset_pulse_error", int'(pulse_error), 0);
    chk("reset_signal_lost", int'(signal_lost), 1);
    rst = 1'b0;

    // LEFT frames
    pulse(1000, 3000, 1'b0, 2'b01, 1'b0);
    chk("lost_after_first_frame", int'(signal_lost), 0);
    pulse(1000, 3000, 1'b0, 2'b01, 1'b0);

    // Band edges
    pulse(1400, 500, 1'b0, 2'b00, 1'b0);
    pulse(1600, 500, 1'b0, 2'b00, 1'b0);
    pulse(1900, 500, 1'b0, 2'b11, 1'b0);
    pulse(2100, 500, 1'b0, 2'b11, 1'b0);
    pulse(1399, 500, 1'b1, 2'b11, 1'b0);
    pulse(2101, 500, 1'b1, 2'b11, 1'b0);
    chk("dir_held_after_errors", int'(direction), 3);

    // Loss of signal after a RIGHT frame, exactly T_LOST after the detected rise
    pulse(2000, 0, 1'b0, 2'b11, 1'b0);
    repeat (last_rise + 40002 - cyc) @(negedge clk);
    chk("lost_not_yet", int'(signal_lost), 0);
    chk("dir_before_loss", int'(direction), 3);
    @(negedge clk);
    chk("lost_at_timeout", int'(signal_lost), 1);
    chk("dir_rest_at_timeout", int'(direction), 0);
    repeat (100) @(negedge clk);
    pulse(1000, 500, 1'b0, 2'b01, 1'b0);
    chk("lost_cleared", int'(signal_lost), 0);

    // Stuck-high input
    pulse(5000, 500, 1'b1, 2'b01, 1'b1);
    chk("dir_held_after_stuck", int'(direction), 1);
    pulse(1500, 500, 1'b0, 2'b00, 1'b0);

    // Reset in the middle of a pulse
    @(negedge clk);
    pwm_in = 1'b1;
    repeat (800) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midreset_direction", int'(direction), 0);
    chk("midreset_valid", int'(valid), 0);
    chk("midreset_pulse_error", int'(pulse_error), 0);
    chk("midreset_signal_lost", int'(signal_lost), 1);
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    pulse(1000, 500, 1'b0, 2'b01, 1'b0);
    chk("lost_cleared_after_reset", int'(signal_lost), 0);

    // Single-cycle glitches
    for (int i = 0; i < 3; i++) pulse(1, 300, 1'b1, 2'b01, 1'b0);
    chk("dir_after_glitches", int'(direction), 1);

    repeat (20) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
